id_ex_stage: RTL

- Pipeline register between decode and execute. Directly upstream of the ALU.
- Captures decoded operands and control each cycle, and resolves data forwarding from the EX/MEM and MEM/WB stages.
- Drives the ALU A/B operands and the 3-bit ALU control.
- Also flags load-use hazards back to the hazard/stall logic.

---
 rtl/id_ex_stage.sv | 118 +++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands/control,
// resolves EX/MEM and MEM/WB forwarding, and flags load-use hazards.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic [2:0]        alu_control_d,
    input  logic              alu_src_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic [1:0]        result_src_d,
    input  logic [REG_AW-1:0] rd_m,
    input  logic              reg_write_m,
    input  logic [XLEN-1:0]   alu_result_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_w,
    input  logic [XLEN-1:0]   result_w,
    output logic [XLEN-1:0]   src_a_e,
    output logic [XLEN-1:0]   src_b_e,
    output logic [2:0]        alu_control_e,
    output logic [XLEN-1:0]   write_data_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [REG_AW-1:0] rd_e,
    output logic              reg_write_e,
    output logic              mem_write_e,
    output logic              valid_e,
    output logic [1:0]        result_src_e,
    output logic              load_use_hazard
);

    logic [XLEN-1:0]   rd1_e;
    logic [XLEN-1:0]   rd2_e;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic              alu_src_e;
    logic [XLEN-1:0]   fa;
    logic [XLEN-1:0]   fb;

    // Newest producer wins; x0 is hardwired zero and never forwarded.
    function automatic logic [XLEN-1:0] forward(
        input logic [REG_AW-1:0] rs,
        input logic [XLEN-1:0]   reg_val,
        input logic              wen_m,
        input logic [REG_AW-1:0] dst_m,
        input logic [XLEN-1:0]   val_m,
        input logic              wen_w,
        input logic [REG_AW-1:0] dst_w,
        input logic [XLEN-1:0]   val_w
    );
        if (wen_m && (dst_m != '0) && (dst_m == rs))
            return val_m;
        else if (wen_w && (dst_w != '0) && (dst_w == rs))
            return val_w;
        else
            return reg_val;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            valid_e       <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            result_src_e  <= '0;
            alu_control_e <= '0;
            alu_src_e     <= 1'b0;
            rd_e          <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            pc_e          <= '0;
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_e         <= '0;
        end else if (!stall_e) begin
            // An empty decode slot still moves data but never enables side effects.
            valid_e       <= valid_d;
            reg_write_e   <= reg_write_d & valid_d;
            mem_write_e   <= mem_write_d & valid_d;
            result_src_e  <= result_src_d;
            alu_control_e <= alu_control_d;
            alu_src_e     <= alu_src_d;
            rd_e          <= rd_d;
            rs1_e         <= rs1_d;
            rs2_e         <= rs2_d;
            pc_e          <= pc_d;
            rd1_e         <= rd1_d;
            rd2_e         <= rd2_d;
            imm_e         <= imm_d;
        end
    end

    always_comb begin
        fa = forward(rs1_e, rd1_e, reg_write_m, rd_m, alu_result_m,
                     reg_write_w, rd_w, result_w);
        fb = forward(rs2_e, rd2_e, reg_write_m, rd_m, alu_result_m,
                     reg_write_w, rd_w, result_w);
        src_a_e      = fa;
        write_data_e = fb;
        src_b_e      = alu_src_e ? imm_e : fb;
    end

    assign load_use_hazard = valid_e & reg_write_e & (result_src_e == 2'b01) &
                             (rd_e != '0) & valid_d &
                             ((rs1_d == rd_e) | (rs2_d == rd_e));

endmodule
